counter_ctrl: RTL and testbench
===============================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, counter width in bits.
REQ-002 SHALL have parameter REPW, default 8, pass-count width in bits.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_cfg_valid  input  1  configuration offer.
REQ-006 SHALL have port o_cfg_ready  output  1  configuration can be accepted.
REQ-007 SHALL have port i_cfg_setup  input  WIDTH  terminal/start magnitude.
REQ-008 SHALL have port i_cfg_desc  input  1  1 = count down, 0 = count up.
REQ-009 SHALL have port i_cfg_repeat  input  REPW  passes to run; 0 = free-run.
REQ-010 SHALL have port i_start  input  1  start counting from ARMED.
REQ-011 SHALL have port i_stop  input  1  abort to IDLE.
REQ-012 SHALL have port i_done_ack  input  1  acknowledge completion.
REQ-013 SHALL have port o_value  output  WIDTH  current count.
REQ-014 SHALL have port o_match  output  1  count at finish value while running.
REQ-015 SHALL have port o_busy  output  1  high in RUN.
REQ-016 SHALL have port o_done  output  1  completion flag, level.
REQ-017 SHALL have port o_state  output  2  IDLE=0, ARMED=1, RUN=2, DONE=3.

Function
REQ-018 SHALL use states IDLE, ARMED, RUN, DONE; o_state equals current state.
REQ-019 SHALL drive o_cfg_ready combinationally high only in IDLE and DONE.
REQ-020 SHALL accept config when i_cfg_valid && o_cfg_ready: latch setup, desc, repeat into shadow registers, load remaining-pass counter with repeat, go ARMED next cycle.
REQ-021 SHALL on accept load o_value with start value: setup if desc, else 0; finish value is 0 if desc, else setup.
REQ-022 SHALL in ARMED with i_start high (i_stop low) go RUN next cycle; o_value holds start value until first RUN step; i_start outside ARMED SHALL be ignored.
REQ-023 SHALL in RUN step o_value by 1 each cycle toward finish (+1 up, -1 down); one pass = setup+1 cycles.
REQ-024 SHALL register o_match high exactly for cycles in which state is RUN and o_value equals finish value; low otherwise.
REQ-025 SHALL at o_value == finish in RUN: if repeat==0 reload start value; else decrement remaining passes and reload, or if it reaches 0 go DONE with o_value held at finish.
REQ-026 SHALL with setup==0 keep o_value at 0 and o_match high every RUN cycle, each cycle counting one pass.
REQ-027 SHALL in DONE hold o_done=1 until i_done_ack (-> IDLE) or config accept (-> ARMED); both clear o_done next cycle.
REQ-028 SHALL give config accept priority over i_done_ack when simultaneous in DONE.
REQ-029 SHALL in ARMED or RUN with i_stop high go IDLE next cycle, o_value holding last value, o_match low, o_done unchanged (0); i_stop SHALL beat i_start and a final finish in the same cycle.
REQ-030 SHALL assert o_busy only in RUN, registered with the state.
REQ-031 SHALL perform all arithmetic modulo 2^WIDTH / 2^REPW; counts never pass finish, so no wrap occurs.

Reset
REQ-032 SHALL on i_rst_n low, immediately and independent of i_clk, force IDLE, o_value=0, o_match=0, o_busy=0, o_done=0, shadow and pass registers 0.
REQ-033 SHALL leave reset on the first rising edge after i_rst_n deasserts, with o_cfg_ready=1.
REQ-034 SHALL abandon any operation in progress on reset without producing o_match or o_done.

Verification
REQ-035 SHALL verify: setup=3, up, repeat=2, start -> o_value 0,1,2,3,0,1,2,3; o_match on both 3s; DONE with o_value=3, o_done=1.
REQ-036 SHALL verify: setup=2, down, repeat=0 -> 2,1,0,2,1,0,... o_match at each 0, never DONE; i_stop -> IDLE, o_value held.
REQ-037 SHALL verify: setup=0, up, repeat=3 -> o_match high 3 consecutive cycles, then DONE.
REQ-038 SHALL verify: i_rst_n low mid-RUN between edges -> outputs zero before next edge, o_state=0.
REQ-039 SHALL verify: in DONE, i_cfg_valid and i_done_ack together -> ARMED, o_done=0, new config loaded.
REQ-040 SHALL verify: i_stop on the cycle of the final finish (setup=1, repeat=1) -> IDLE, o_done stays 0.

Source files
------------

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - configurable up/down pass counter with ARMED/RUN/DONE control
module counter_ctrl #(
  parameter int WIDTH = 16,
  parameter int REPW  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [WIDTH-1:0] i_cfg_setup,
  input  logic             i_cfg_desc,
  input  logic [REPW-1:0]  i_cfg_repeat,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_done_ack,
  output logic [WIDTH-1:0] o_value,
  output logic             o_match,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [WIDTH-1:0] VAL_ONE = WIDTH'(1);
  localparam logic [REPW-1:0]  REP_ONE = REPW'(1);

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] value_q,  value_d;
  logic [WIDTH-1:0] setup_q,  setup_d;
  logic             desc_q,   desc_d;
  logic [REPW-1:0]  repeat_q, repeat_d;
  logic [REPW-1:0]  remain_q, remain_d;
  logic             match_q,  match_d;

  logic [WIDTH-1:0] start_val, finish_val, finish_d;
  logic             accept;

  assign start_val   = desc_q ? setup_q : '0;
  assign finish_val  = desc_q ? '0 : setup_q;
  assign o_cfg_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept      = i_cfg_valid && o_cfg_ready;

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    setup_d  = setup_q;
    desc_d   = desc_q;
    repeat_d = repeat_q;
    remain_d = remain_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A new configuration outranks a completion acknowledge.
        if (accept) begin
          setup_d  = i_cfg_setup;
          desc_d   = i_cfg_desc;
          repeat_d = i_cfg_repeat;
          remain_d = i_cfg_repeat;
          value_d  = i_cfg_desc ? i_cfg_setup : '0;
          state_d  = ST_ARMED;
        end else if (state_q == ST_DONE && i_done_ack) begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (i_start) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (value_q == finish_val) begin
          if (repeat_q == '0) begin
            value_d = start_val;
          end else if (remain_q == REP_ONE) begin
            remain_d = '0;
            state_d  = ST_DONE;
          end else begin
            remain_d = remain_q - REP_ONE;
            value_d  = start_val;
          end
        end else begin
          value_d = desc_q ? (value_q - VAL_ONE) : (value_q + VAL_ONE);
        end
      end
    endcase

    finish_d = desc_d ? '0 : setup_d;
    match_d  = (state_d == ST_RUN) && (value_d == finish_d);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      value_q  <= '0;
      setup_q  <= '0;
      desc_q   <= 1'b0;
      repeat_q <= '0;
      remain_q <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      setup_q  <= setup_d;
      desc_q   <= desc_d;
      repeat_q <= repeat_d;
      remain_q <= remain_d;
      match_q  <= match_d;
    end
  end

  assign o_value = value_q;
  assign o_match = match_q;
  assign o_busy  = (state_q == ST_RUN);
  assign o_done  = (state_q == ST_DONE);
  assign o_state = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - directed and random checks of counter_ctrl against a pass/position model
module tb_counter_ctrl;

  localparam int WIDTH = 16;
  localparam int REPW  = 8;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_cfg_valid;
  logic             o_cfg_ready;
  logic [WIDTH-1:0] i_cfg_setup;
  logic             i_cfg_desc;
  logic [REPW-1:0]  i_cfg_repeat;
  logic             i_start;
  logic             i_stop;
  logic             i_done_ack;
  logic [WIDTH-1:0] o_value;
  logic             o_match;
  logic             o_busy;
  logic             o_done;
  logic [1:0]       o_state;

  counter_ctrl #(.WIDTH(WIDTH), .REPW(REPW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
    .i_cfg_setup(i_cfg_setup), .i_cfg_desc(i_cfg_desc), .i_cfg_repeat(i_cfg_repeat),
    .i_start(i_start), .i_stop(i_stop), .i_done_ack(i_done_ack),
    .o_value(o_value), .o_match(o_match), .o_busy(o_busy), .o_done(o_done),
    .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Model: a pass is positions 0..setup; the value is derived from the position.
  int m_st, m_setup, m_desc, m_rep, m_pos, m_passes, m_val;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_setup = 0; m_desc = 0; m_rep = 0; m_pos = 0; m_passes = 0; m_val = 0;
  endtask

  task automatic model_accept();
    m_setup = int'(i_cfg_setup); m_desc = int'(i_cfg_desc); m_rep = int'(i_cfg_repeat);
    m_pos = 0; m_passes = 0;
    m_val = m_desc ? m_setup : 0;
    m_st = 1;
  endtask

  task automatic model_step();
    case (m_st)
      0: if (i_cfg_valid) model_accept();
      1: begin
        if (i_stop) m_st = 0;
        else if (i_start) m_st = 2;
      end
      2: begin
        if (i_stop) m_st = 0;
        else begin
          if (m_pos == m_setup) begin
            m_passes++;
            if (m_rep != 0 && m_passes == m_rep) m_st = 3;
            else m_pos = 0;
          end else begin
            m_pos++;
          end
          m_val = m_desc ? (m_setup - m_pos) : m_pos;
        end
      end
      default: begin
        if (i_cfg_valid) model_accept();
        else if (i_done_ack) m_st = 0;
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, int'(o_state), m_st);
    chk({tag, ".value"}, int'(o_value), m_val);
    chk({tag, ".match"}, int'(o_match), int'(m_st == 2 && m_pos == m_setup));
    chk({tag, ".busy"},  int'(o_busy),  int'(m_st == 2));
    chk({tag, ".done"},  int'(o_done),  int'(m_st == 3));
    chk({tag, ".ready"}, int'(o_cfg_ready), int'(m_st == 0 || m_st == 3));
  endtask

  task automatic tick(input string tag);
    @(posedge i_clk);
    model_step();
    #2;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    i_cfg_valid = 0; i_start = 0; i_stop = 0; i_done_ack = 0;
  endtask

  task automatic configure(input int setup, input int desc, input int rep, input string tag);
    i_cfg_valid = 1; i_cfg_setup = WIDTH'(setup); i_cfg_desc = desc[0]; i_cfg_repeat = REPW'(rep);
    tick(tag);
    i_cfg_valid = 0;
  endtask

  task automatic go(input string tag);
    i_start = 1;
    tick(tag);
    i_start = 0;
  endtask

  int exp_up[8];

  initial begin
    exp_up = '{0, 1, 2, 3, 0, 1, 2, 3};
    i_rst_n = 0; i_cfg_setup = '0; i_cfg_desc = 0; i_cfg_repeat = '0;
    idle_inputs();
    model_reset();
    #12;
    check_all("reset");
    #1 i_rst_n = 1;

    // Up count, two passes, then DONE.
    configure(3, 0, 2, "cfg_up");
    chk("armed_value", int'(o_value), 0);
    go("start_up");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("up_seq%0d", i), int'(o_value), exp_up[i]);
      chk($sformatf("up_match%0d", i), int'(o_match), int'(exp_up[i] == 3));
      tick("up_run");
    end
    chk("up_done_flag", int'(o_done), 1);
    chk("up_done_value", int'(o_value), 3);
    tick("up_hold");
    i_done_ack = 1; tick("up_ack"); i_done_ack = 0;
    chk("ack_state", int'(o_state), 0);

    // Down free-run then stop.
    configure(2, 1, 0, "cfg_down");
    go("start_down");
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("down_seq%0d", i), int'(o_value), 2 - (i % 3));
      tick("down_run");
    end
    chk("down_never_done", int'(o_state), 2);
    i_stop = 1; tick("down_stop"); i_stop = 0;
    chk("down_stop_state", int'(o_state), 0);
    chk("down_stop_value", int'(o_value), 1);
    tick("down_idle");

    // setup=0: every RUN cycle is a full pass.
    configure(0, 0, 3, "cfg_zero");
    go("start_zero");
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("zero_match%0d", i), int'(o_match), 1);
      tick("zero_run");
    end
    chk("zero_done", int'(o_state), 3);

    // New config while DONE beats the acknowledge.
    i_done_ack = 1;
    configure(4, 1, 1, "cfg_in_done");
    i_done_ack = 0;
    chk("done_cfg_state", int'(o_state), 1);
    chk("done_cfg_value", int'(o_value), 4);
    chk("done_cfg_done", int'(o_done), 0);

    // Async reset in the middle of a RUN cycle.
    go("start_rst");
    tick("rst_run");
    #3 i_rst_n = 0;
    #1;
    model_reset();
    check_all("async_rst");
    #2 i_rst_n = 1;
    tick("after_rst");

    // Stop coincides with the final finish.
    configure(1, 0, 1, "cfg_last");
    go("start_last");
    tick("last_run");
    chk("last_at_finish", int'(o_match), 1);
    i_stop = 1; tick("last_stop"); i_stop = 0;
    chk("last_state", int'(o_state), 0);
    chk("last_done", int'(o_done), 0);
    chk("last_value", int'(o_value), 1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      i_cfg_valid  = ($urandom % 4) == 0;
      i_cfg_setup  = WIDTH'($urandom_range(0, 4));
      i_cfg_desc   = 1'($urandom % 2);
      i_cfg_repeat = REPW'($urandom_range(0, 3));
      i_start      = 1'($urandom % 2);
      i_stop       = ($urandom % 16) == 0;
      i_done_ack   = ($urandom % 4) == 0;
      tick("rand");
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
